// File: rtl/ram_request_arbiter.sv
// Single-port RAM arbiter: data/writeback port has priority, instruction
// fetch ports are round-robin, a starvation counter bounds fetch latency.
package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

module ram_request_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS         = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [CPUS-1:0]             iREN,
  input  logic [CPUS-1:0][31:0]       iaddr,
  output logic [CPUS-1:0]             iwait,
  output logic [31:0]                 iload,
  input  logic                        cREN,
  input  logic                        cWEN,
  input  logic [31:0]                 caddr,
  input  logic [31:0]                 cstore,
  output logic                        cwait,
  output logic [31:0]                 cload,
  input  ramstate_t                   ramstate,
  input  logic [31:0]                 ramload,
  output logic                        ramREN,
  output logic                        ramWEN,
  output logic [31:0]                 ramaddr,
  output logic [31:0]                 ramstore,
  output logic [1:0]                  grant_id,
  output logic [$clog2(CPUS)-1:0]     rr_ptr
);

  localparam int PW = $clog2(CPUS);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_D = 2'd1,
    S_GRANT_I = 2'd2
  } state_t;

  state_t           r_state, w_state_n;
  logic [PW-1:0]    r_rr_ptr, w_rr_n;
  logic [PW-1:0]    r_gidx, w_gidx_n;
  logic [CNT_W-1:0] r_starve, w_starve_n;

  logic          w_instr_pend;
  logic          w_data_req;
  logic          w_starved;
  logic [PW-1:0] w_win;
  logic [PW-1:0] w_idx;

  assign w_instr_pend = |iREN;
  assign w_data_req   = cREN | cWEN;
  assign w_starved    = w_instr_pend && (r_starve == LIMIT);

  assign iload  = ramload;
  assign cload  = ramload;
  assign rr_ptr = r_rr_ptr;

  // lowest offset from rr_ptr wins; written last so it overrides
  always_comb begin
    w_win = r_rr_ptr;
    w_idx = r_rr_ptr;
    for (int k = CPUS-1; k >= 0; k--) begin
      w_idx = r_rr_ptr + PW'(k);
      if (iREN[w_idx]) w_win = w_idx;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_rr_n     = r_rr_ptr;
    w_gidx_n   = r_gidx;
    w_starve_n = r_starve;
    iwait      = '1;
    cwait      = 1'b1;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    grant_id   = 2'd0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_instr_pend) w_starve_n = '0;
        if (w_data_req && !w_starved) begin
          w_state_n = S_GRANT_D;
        end else if (w_instr_pend) begin
          w_state_n = S_GRANT_I;
          w_gidx_n  = w_win;
        end
      end
      S_GRANT_D: begin
        grant_id = 2'd1;
        ramWEN   = cWEN;
        ramREN   = cREN & ~cWEN;
        ramaddr  = caddr;
        ramstore = cstore;
        if (!w_data_req) begin
          w_state_n = S_IDLE;
        end else if (ramstate == ACCESS) begin
          cwait     = 1'b0;
          w_state_n = S_IDLE;
          if (w_instr_pend && r_starve != LIMIT)
            w_starve_n = r_starve + CNT_W'(1);
        end
      end
      S_GRANT_I: begin
        grant_id = 2'd2;
        ramREN   = 1'b1;
        ramaddr  = iaddr[r_gidx];
        // abort wins over a same-cycle ACCESS
        if (!iREN[r_gidx]) begin
          w_state_n = S_IDLE;
        end else if (ramstate == ACCESS) begin
          iwait[r_gidx] = 1'b0;
          w_rr_n        = r_gidx + PW'(1);
          w_starve_n    = '0;
          w_state_n     = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_gidx   <= '0;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_n;
      r_rr_ptr <= w_rr_n;
      r_gidx   <= w_gidx_n;
      r_starve <= w_starve_n;
    end
  end

endmodule

// File: tb/tb_ram_request_arbiter.sv
// Directed cycle-by-cycle vectors plus hand sequences for
// async reset mid-grant and a bounded single-fetch latency check.
module tb_ram_request_arbiter;
  import cpu_types_pkg::*;

  localparam logic [31:0] Z   = 32'h0;
  localparam logic [31:0] CA  = 32'h0000_0200;
  localparam logic [31:0] CS  = 32'hDEAD_BEEF;
  localparam logic [31:0] IA0 = 32'h0000_0100;
  localparam logic [31:0] IA1 = 32'h0000_0104;
  localparam int NV = 37;

  logic            CLK, nRST;
  logic [1:0]      iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]      iwait;
  logic [31:0]     iload;
  logic            cREN, cWEN;
  logic [31:0]     caddr, cstore;
  logic            cwait;
  logic [31:0]     cload;
  ramstate_t       ramstate;
  logic [31:0]     ramload;
  logic            ramREN, ramWEN;
  logic [31:0]     ramaddr, ramstore;
  logic [1:0]      grant_id;
  logic [0:0]      rr_ptr;

  int checks = 0;
  int failures = 0;

  ram_request_arbiter #(
    .CPUS(2), .STARVE_LIMIT(4), .CNT_W(3)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload),
    .cREN(cREN), .cWEN(cWEN),
    .caddr(caddr), .cstore(cstore),
    .cwait(cwait), .cload(cload),
    .ramstate(ramstate), .ramload(ramload),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .grant_id(grant_id), .rr_ptr(rr_ptr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  iren;
    logic        cr;
    logic        cw;
    ramstate_t   rs;
    logic [1:0]  e_iw;
    logic        e_cw;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_store;
    logic [1:0]  e_gid;
    logic [0:0]  e_rr;
  } vec_t;

  vec_t vt [NV];

  task automatic chk(input string name, input logic [95:0] got,
                     input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  function automatic logic [71:0] pack_out();
    return {iwait, cwait, ramREN, ramWEN, grant_id, rr_ptr,
            ramaddr, ramstore};
  endfunction

  function automatic logic [71:0] pack_exp(input vec_t v);
    return {v.e_iw, v.e_cw, v.e_ren, v.e_wen, v.e_gid, v.e_rr,
            v.e_addr, v.e_store};
  endfunction

  int done_cyc;

  initial begin
    // starvation: 4 data writes, then CPU1 fetch, then data again
    vt[0]  = '{2'b10,1'b0,1'b1,ACCESS, 2'b11,1'b0,1'b0,1'b1,CA,CS,2'd1,1'b0};
    vt[1]  = '{2'b10,1'b0,1'b1,ACCESS, 2'b11,1'b1,1'b0,1'b0,Z,Z,2'd0,1'b0};
    vt[2]  = vt[0];
    vt[3]  = vt[1];
    vt[4]  = vt[0];
    vt[5]  = vt[1];
    vt[6]  = vt[0];
    vt[7]  = vt[1];
    vt[8]  = '{2'b10,1'b0,1'b1,ACCESS, 2'b01,1'b1,1'b1,1'b0,IA1,Z,2'd2,1'b0};
    vt[9]  = vt[1];
    vt[10] = vt[0];
    // round robin with both fetchers pending
    vt[11] = '{2'b11,1'b0,1'b0,ACCESS, 2'b11,1'b1,1'b0,1'b0,Z,Z,2'd0,1'b0};
    vt[12] = '{2'b11,1'b0,1'b0,ACCESS, 2'b10,1'b1,1'b1,1'b0,IA0,Z,2'd2,1'b0};
    vt[13] = '{2'b11,1'b0,1'b0,ACCESS, 2'b11,1'b1,1'b0,1'b0,Z,Z,2'd0,1'b1};
    vt[14] = '{2'b11,1'b0,1'b0,ACCESS, 2'b01,1'b1,1'b1,1'b0,IA1,Z,2'd2,1'b1};
    vt[15] = vt[11];
    vt[16] = vt[12];
    vt[17] = vt[13];
    vt[18] = vt[14];
    // single fetch, two BUSY cycles
    vt[19] = '{2'b01,1'b0,1'b0,BUSY,   2'b11,1'b1,1'b0,1'b0,Z,Z,2'd0,1'b0};
    vt[20] = '{2'b01,1'b0,1'b0,BUSY,   2'b11,1'b1,1'b1,1'b0,IA0,Z,2'd2,1'b0};
    vt[21] = vt[20];
    vt[22] = '{2'b01,1'b0,1'b0,ACCESS, 2'b10,1'b1,1'b1,1'b0,IA0,Z,2'd2,1'b0};
    vt[23] = '{2'b00,1'b0,1'b0,ACCESS, 2'b11,1'b1,1'b0,1'b0,Z,Z,2'd0,1'b1};
    // fetch abort with ERROR hold and abort+ACCESS together
    vt[24] = '{2'b01,1'b0,1'b0,BUSY,   2'b11,1'b1,1'b0,1'b0,Z,Z,2'd0,1'b1};
    vt[25] = '{2'b01,1'b0,1'b0,BUSY,   2'b11,1'b1,1'b1,1'b0,IA0,Z,2'd2,1'b1};
    vt[26] = '{2'b01,1'b0,1'b0,ERROR,  2'b11,1'b1,1'b1,1'b0,IA0,Z,2'd2,1'b1};
    vt[27] = '{2'b00,1'b0,1'b0,ACCESS, 2'b11,1'b1,1'b1,1'b0,IA0,Z,2'd2,1'b1};
    vt[28] = '{2'b00,1'b0,1'b0,ACCESS, 2'b11,1'b1,1'b0,1'b0,Z,Z,2'd0,1'b1};
    // data read abort
    vt[29] = '{2'b00,1'b1,1'b0,BUSY,   2'b11,1'b1,1'b0,1'b0,Z,Z,2'd0,1'b1};
    vt[30] = '{2'b00,1'b1,1'b0,BUSY,   2'b11,1'b1,1'b1,1'b0,CA,CS,2'd1,1'b1};
    vt[31] = '{2'b00,1'b0,1'b0,ACCESS, 2'b11,1'b1,1'b0,1'b0,CA,CS,2'd1,1'b1};
    vt[32] = vt[28];
    // cWEN beats cREN; leave a write grant open for the reset test
    vt[33] = '{2'b10,1'b1,1'b1,ACCESS, 2'b11,1'b1,1'b0,1'b0,Z,Z,2'd0,1'b1};
    vt[34] = '{2'b10,1'b1,1'b1,ACCESS, 2'b11,1'b0,1'b0,1'b1,CA,CS,2'd1,1'b1};
    vt[35] = '{2'b10,1'b1,1'b1,BUSY,   2'b11,1'b1,1'b0,1'b0,Z,Z,2'd0,1'b1};
    vt[36] = '{2'b10,1'b1,1'b1,BUSY,   2'b11,1'b1,1'b0,1'b1,CA,CS,2'd1,1'b1};

    nRST = 1'b0;
    iREN = 2'b11;
    cREN = 1'b1;
    cWEN = 1'b1;
    iaddr[0] = IA0;
    iaddr[1] = IA1;
    caddr = CA;
    cstore = CS;
    ramstate = BUSY;
    ramload = 32'h1234_5678;

    @(negedge CLK);
    #1;
    chk("reset_iwait", 96'(iwait), 96'(2'b11));
    chk("reset_cwait", 96'(cwait), 96'(1'b1));
    chk("reset_ren", 96'(ramREN), 96'(1'b0));
    chk("reset_wen", 96'(ramWEN), 96'(1'b0));
    chk("reset_addr", 96'(ramaddr), 96'(Z));
    chk("reset_store", 96'(ramstore), 96'(Z));
    chk("reset_gid", 96'(grant_id), 96'(2'd0));
    chk("reset_rr", 96'(rr_ptr), 96'(1'b0));
    nRST = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      iREN = vt[i].iren;
      cREN = vt[i].cr;
      cWEN = vt[i].cw;
      ramstate = vt[i].rs;
      ramload = 32'hA5A5_0000 | 32'(i);
      #1;
      chk($sformatf("vec%0d", i), 96'(pack_out()), 96'(pack_exp(vt[i])));
      chk($sformatf("vec%0d_load", i), {32'h0, iload, cload},
          {32'h0, 32'hA5A5_0000 | 32'(i), 32'hA5A5_0000 | 32'(i)});
    end

    // async reset in the middle of an open write grant
    #2;
    chk("pre_reset_starve", 96'(dut.r_starve), 96'(3'd1));
    chk("pre_reset_wen", 96'(ramWEN), 96'(1'b1));
    nRST = 1'b0;
    #1;
    chk("async_wen", 96'(ramWEN), 96'(1'b0));
    chk("async_gid", 96'(grant_id), 96'(2'd0));
    chk("async_cwait", 96'(cwait), 96'(1'b1));
    chk("async_addr", 96'(ramaddr), 96'(Z));
    chk("async_starve", 96'(dut.r_starve), 96'(3'd0));

    iREN = 2'b10;
    cREN = 1'b0;
    cWEN = 1'b0;
    ramstate = ACCESS;
    @(negedge CLK);
    nRST = 1'b1;

    done_cyc = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      #1;
      if (iwait[1] == 1'b0) begin
        done_cyc = c;
        break;
      end
    end
    chk("fetch_latency", 96'(done_cyc), 96'(1));
    chk("fetch_addr", 96'(ramaddr), 96'(IA1));
    iREN = 2'b00;
    @(negedge CLK);
    #1;
    chk("post_fetch_iwait", 96'(iwait), 96'(2'b11));
    chk("post_fetch_rr", 96'(rr_ptr), 96'(1'b0));
    chk("post_fetch_gid", 96'(grant_id), 96'(2'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_request_arbiter.md
Name: ram_request_arbiter

Overview:
- Single-port RAM arbiter between CPUS instruction-fetch requesters and the coherence controller's data/writeback port.
- Sits between the caches/coherence controller and the RAM model.
- Registered grant FSM: data traffic has priority, instruction requesters are served round-robin, and a starvation counter bounds instruction latency.
- Provides a clean, registered request stream to RAM in place of combinational muxing.

Parameters:
- CPUS, 2: number of instruction requesters (power of two, ≥2).
- STARVE_LIMIT, 4: consecutive data grants with instruction pending before an instruction grant is forced.
- CNT_W, 3: width of the starvation counter (must hold STARVE_LIMIT).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iREN  in  CPUS  per-CPU instruction read request.
- iaddr  in  CPUS x 32  per-CPU instruction word address.
- iwait  out  CPUS  per-CPU wait; low for exactly the completing cycle.
- iload  out  32  instruction data (ramload passthrough, all CPUs).
- cREN  in  1  coherence-port read request.
- cWEN  in  1  coherence-port write request (wins over cREN if both high).
- caddr  in  32  coherence-port address.
- cstore  in  32  coherence-port write data.
- cwait  out  1  coherence-port wait; low for exactly the completing cycle.
- cload  out  32  coherence read data (ramload passthrough).
- ramstate  in  2  ramstate_t from cpu_types_pkg (FREE, BUSY, ACCESS, ERROR).
- ramload  in  32  RAM read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- grant_id  out  2  debug: 0 none, 1 data, 2 instr.
- rr_ptr  out  log2(CPUS)  debug: next instruction CPU to consider.

Behaviour:
- Reset (async, nRST low): state IDLE, rr_ptr 0, starve_cnt 0, grant registers 0. Outputs: all iwait 1, cwait 1, ramREN 0, ramWEN 0, ramaddr 0, ramstore 0, grant_id 0.
- States: IDLE, GRANT_D, GRANT_I.
- IDLE arbitration, registered, evaluated each cycle:
  - instr_pend = any iREN.
  - If (cREN|cWEN) and not (instr_pend and starve_cnt==STARVE_LIMIT): go to GRANT_D.
  - Else if instr_pend: go to GRANT_I. The winner is the first asserted iREN searching from rr_ptr upward, modulo CPUS; latch its index as gidx.
  - Else: stay in IDLE.
- In IDLE, ramREN and ramWEN are 0 and all waits are 1.
- GRANT_D:
  - ramWEN=cWEN; ramREN=cREN&~cWEN; ramaddr=caddr; ramstore=cstore.
  - When ramstate==ACCESS: cwait=0 that cycle, go to IDLE.
- GRANT_I:
  - ramREN=1; ramWEN=0; ramaddr=iaddr[gidx]; ramstore=0.
  - When ramstate==ACCESS: iwait[gidx]=0 that cycle, rr_ptr<=gidx+1 (wraps), go to IDLE.
- Latency: request seen at edge N; RAM enable asserted in cycle N+1; completion in the cycle RAM returns ACCESS. At least one IDLE cycle separates consecutive grants, so back-to-back hits take 2 cycles minimum.
- Abort: if the granted requester deasserts its enable before ACCESS, return to IDLE the next edge. No wait-low pulse is issued and rr_ptr/starve_cnt are unchanged.
- Simultaneous abort and ACCESS in the same cycle: treat as abort (no completion).
- ramstate ERROR or BUSY: hold the grant, keep wait high, no timeout.
- Starvation counter:
  - On GRANT_D completion with instr_pend: starve_cnt++, saturating at STARVE_LIMIT.
  - On GRANT_I completion, or any IDLE cycle with instr_pend==0: starve_cnt<=0.
- Ungranted requesters always see wait=1.
- iload and cload always equal ramload; qualify with wait.
- Address and store data are sampled live during the grant, not latched. Requesters must hold them stable until wait falls.

Test Plan:
- Reset check: nRST low with all requests high → iwait=2'b11, cwait=1, ramREN=0, ramWEN=0, ramaddr=0, grant_id=0. Release reset → GRANT_D on the next edge.
- Single instr fetch: iREN=2'b01, iaddr[0]=0x100, RAM ACCESS after 2 BUSY cycles → ramREN=1 and ramaddr=0x100 for 3 cycles; iwait[0]=0 on the third; rr_ptr becomes 1.
- Round-robin: iREN=2'b11 held, RAM always ACCESS, no data traffic → completion order CPU0, CPU1, CPU0, CPU1; each completion is 2 cycles apart.
- Data priority and starvation: cWEN and iREN[1] held, STARVE_LIMIT=4, caddr=0x200, cstore=0xDEADBEEF → 4 writes (ramWEN=1, ramstore=0xDEADBEEF), then 1 instr grant to CPU1, then data resumes.
- Abort: GRANT_I with ramstate BUSY; drop iREN[0] → IDLE next cycle, iwait[0] never low, rr_ptr stays 0.
- Async reset mid-grant: assert nRST during GRANT_D with ramWEN=1 → ramWEN falls immediately without a clock; state IDLE, starve_cnt 0.
